// File: rtl/example_top_pkg.sv
// Shared types and constants for the RGB colour-cycler demo: colour encoding,
// UART report/command characters and the one-entry TX request record.
package example_top_pkg;

  // One-hot so the state register drives {red, green, blue} directly.
  typedef enum logic [2:0] {
    RED   = 3'b100,
    GREEN = 3'b010,
    BLUE  = 3'b001
  } colour_e;

  localparam logic [7:0] CHR_R = 8'h52;
  localparam logic [7:0] CHR_G = 8'h47;
  localparam logic [7:0] CHR_B = 8'h42;

  localparam logic [7:0] CMD_R = 8'h72;
  localparam logic [7:0] CMD_G = 8'h67;
  localparam logic [7:0] CMD_B = 8'h62;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } tx_req_t;

  function automatic logic [7:0] colour_char(colour_e c);
    case (c)
      RED:     return CHR_R;
      GREEN:   return CHR_G;
      default: return CHR_B;
    endcase
  endfunction

  function automatic colour_e colour_next(colour_e c);
    case (c)
      RED:     return GREEN;
      GREEN:   return BLUE;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/uart_8n1.sv
// 8N1 UART: transmitter with a valid/ready load port and a receiver that
// reports each correctly framed byte as a one-cycle rx_valid pulse.
module uart_8n1 #(
  parameter int BAUD_DIV = 16
) (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       txd,
  input  logic       rxd
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] FULL = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF = BW'(BAUD_DIV / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // ---------------- transmitter ----------------
  logic          tx_busy;
  logic [BW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sr;

  assign tx_ready = !tx_busy;

  // txd is registered: the start bit appears on the edge that loads the byte.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      tx_busy <= 1'b0;
      tx_baud <= '0;
      tx_bit  <= '0;
      tx_sr   <= '1;
      txd     <= 1'b1;
    end else if (!tx_busy) begin
      if (tx_valid) begin
        tx_busy <= 1'b1;
        tx_baud <= '0;
        tx_bit  <= '0;
        tx_sr   <= {1'b1, tx_data};
        txd     <= 1'b0;
      end
    end else if (tx_baud == FULL) begin
      tx_baud <= '0;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        txd    <= tx_sr[0];
        tx_sr  <= {1'b1, tx_sr[8:1]};
        tx_bit <= tx_bit + 1'b1;
      end
    end else begin
      tx_baud <= tx_baud + 1'b1;
    end
  end

  // ---------------- receiver ----------------
  logic          rxd_meta, rxd_s, rxd_prev;
  logic [1:0]    rx_st;
  logic [BW-1:0] rx_baud;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sr;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rx_st    <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_st)
        RX_IDLE: begin
          if (rxd_prev && !rxd_s) begin
            rx_st   <= RX_START;
            rx_baud <= '0;
          end
        end
        RX_START: begin
          // Half a bit in: a line back high was only a glitch.
          if (rx_baud == HALF) begin
            rx_baud <= '0;
            rx_bit  <= '0;
            rx_st   <= rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_baud == FULL) begin
            rx_baud <= '0;
            rx_sr   <= {rxd_s, rx_sr[7:1]};
            rx_bit  <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        default: begin
          if (rx_baud == FULL) begin
            rx_baud <= '0;
            rx_st   <= RX_IDLE;
            if (rxd_s) begin
              rx_data  <= rx_sr;
              rx_valid <= 1'b1;
            end
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/example_top.sv
// Board-level demo: steps an RGB LED RED->GREEN->BLUE every LED_PERIOD cycles,
// reports each change over UART TX and accepts r/g/b commands over UART RX.
module example_top
  import example_top_pkg::*;
#(
  parameter int LED_PERIOD = 1024,
  parameter int BAUD_DIV   = 16
) (
  input  logic osc_clk_in,
  input  logic osc_reset_,
  output logic led_red,
  output logic led_green,
  output logic led_blue,
  input  logic button,
  output logic uart_txd,
  input  logic uart_rxd
);
  localparam int CW = $clog2(LED_PERIOD);
  localparam logic [CW-1:0] CNT_MAX = CW'(LED_PERIOD - 1);

  logic          btn_meta, btn_sync;
  logic [CW-1:0] cnt, cnt_nxt;
  colour_e       state, state_nxt, cmd_colour;
  logic          chg, cmd_hit;
  tx_req_t       pend;
  logic          tx_ready, rx_valid;
  logic [7:0]    rx_data;

  assign {led_red, led_green, led_blue} = state;

  always_ff @(posedge osc_clk_in or negedge osc_reset_) begin
    if (!osc_reset_) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
    end else begin
      btn_meta <= button;
      btn_sync <= btn_meta;
    end
  end

  always_comb begin
    cmd_hit    = 1'b0;
    cmd_colour = RED;
    case (rx_data)
      CMD_R:   begin cmd_hit = 1'b1; cmd_colour = RED;   end
      CMD_G:   begin cmd_hit = 1'b1; cmd_colour = GREEN; end
      CMD_B:   begin cmd_hit = 1'b1; cmd_colour = BLUE;  end
      default: ;
    endcase
  end

  // A received command overrides a same-cycle auto-step and restarts the period.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    chg       = 1'b0;
    if (rx_valid && cmd_hit) begin
      state_nxt = cmd_colour;
      cnt_nxt   = '0;
      chg       = 1'b1;
    end else if (btn_sync) begin
      if (cnt == CNT_MAX) begin
        state_nxt = colour_next(state);
        cnt_nxt   = '0;
        chg       = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // A new report always wins over the clear from a same-cycle TX load.
  always_ff @(posedge osc_clk_in or negedge osc_reset_) begin
    if (!osc_reset_) begin
      state <= RED;
      cnt   <= '0;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (chg) begin
        pend.vld  <= 1'b1;
        pend.data <= colour_char(state_nxt);
      end else if (pend.vld && tx_ready) begin
        pend.vld <= 1'b0;
      end
    end
  end

  uart_8n1 #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .gclk     (osc_clk_in),
    .grst_n   (osc_reset_),
    .tx_data  (pend.data),
    .tx_valid (pend.vld),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .txd      (uart_txd),
    .rxd      (uart_rxd)
  );

endmodule

// File: tb/tb_example_top.sv
// Bench for example_top: LED timing, button hold, UART commands and reports,
// with TX frames decoded by a line monitor against a queue of expected chars.
module tb_example_top;
  localparam int LP = 1024;
  localparam int BD = 16;

  logic osc_clk_in = 1'b0;
  logic osc_reset_ = 1'b0;
  logic button     = 1'b1;
  logic uart_rxd   = 1'b1;
  logic led_red, led_green, led_blue, uart_txd;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, base = 0;
  int chg_count = 0, chg_cyc = 0, onehot_err = 0, frame_cnt = 0;
  int c0 = 0, oh0 = 0, f0 = 0;
  logic [2:0] prev_leds = 3'b100;
  logic [7:0] exp_q[$];
  logic [2:0] leds;

  assign leds = {led_red, led_green, led_blue};

  example_top #(.LED_PERIOD(LP), .BAUD_DIV(BD)) dut (
    .osc_clk_in (osc_clk_in),
    .osc_reset_ (osc_reset_),
    .led_red    (led_red),
    .led_green  (led_green),
    .led_blue   (led_blue),
    .button     (button),
    .uart_txd   (uart_txd),
    .uart_rxd   (uart_rxd)
  );

  always #5 osc_clk_in = ~osc_clk_in;
  always @(posedge osc_clk_in) cyc <= cyc + 1;

  // LED activity tracker: chg_cyc is the edge count since reset release.
  always @(negedge osc_clk_in) begin
    if (!$onehot(leds)) onehot_err <= onehot_err + 1;
    if (leds !== prev_leds) begin
      chg_count <= chg_count + 1;
      chg_cyc   <= cyc - base;
    end
    prev_leds <= leds;
  end

  // TX line decoder: samples each bit near its middle, pops the expected char.
  initial begin
    logic [9:0] bits;
    logic [7:0] exp;
    bit abort;
    forever begin
      @(negedge osc_clk_in);
      if (osc_reset_ === 1'b1 && uart_txd === 1'b0) begin
        abort = 1'b0;
        for (int k = 0; k < 10; k++) begin
          for (int j = 0; j < ((k == 0) ? 7 : BD); j++) begin
            @(negedge osc_clk_in);
            if (osc_reset_ !== 1'b1) abort = 1'b1;
          end
          bits[k] = uart_txd;
        end
        if (!abort) begin
          frame_cnt++;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL tx_unexpected: got frame bits %b, expected no frame", bits);
          end else begin
            exp = exp_q.pop_front();
            if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || bits[8:1] !== exp) begin
              n_fail++;
              $display("FAIL tx_frame: got start=%b data=%h stop=%b, expected 0/%h/1",
                       bits[0], bits[8:1], bits[9], exp);
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    osc_reset_ = 1'b0;
    button     = 1'b1;
    uart_rxd   = 1'b1;
    repeat (4) @(negedge osc_clk_in);
    exp_q.delete();
    osc_reset_ = 1'b1;
    base = cyc;
    c0   = chg_count;
    oh0  = onehot_err;
    f0   = frame_cnt;
  endtask

  task automatic wait_rel(input int n);
    while (cyc - base < n) @(negedge osc_clk_in);
  endtask

  task automatic wait_chg(input int k, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge osc_clk_in);
      if (chg_count - c0 >= k) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, output int t0);
    @(negedge osc_clk_in);
    t0 = cyc - base;
    uart_rxd = 1'b0;
    repeat (BD) @(negedge osc_clk_in);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (BD) @(negedge osc_clk_in);
    end
    uart_rxd = stop;
    repeat (BD) @(negedge osc_clk_in);
    uart_rxd = 1'b1;
    repeat (2 * BD) @(negedge osc_clk_in);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge osc_clk_in);
    n_tests++;
    if (leds !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_leds: got %b expected 100", leds);
    end
    n_tests++;
    if (uart_txd !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_txd: got %b expected 1", uart_txd);
    end
  endtask

  task automatic test_autostep();
    bit ok;
    logic [2:0] exp_led;
    do_reset();
    for (int k = 1; k <= 9; k++)
      exp_q.push_back((k % 3 == 1) ? 8'h47 : (k % 3 == 2) ? 8'h42 : 8'h52);
    for (int k = 1; k <= 9; k++) begin
      exp_led = (k % 3 == 1) ? 3'b010 : (k % 3 == 2) ? 3'b001 : 3'b100;
      wait_chg(k, LP + 100, ok);
      n_tests++;
      if (!ok || chg_cyc !== LP * k || leds !== exp_led) begin
        n_fail++;
        $display("FAIL auto_step%0d: got ok=%0d cycle=%0d leds=%b, expected cycle=%0d leds=%b",
                 k, ok, chg_cyc, leds, LP * k, exp_led);
      end
    end
    wait_rel(10000);
    n_tests++;
    if (chg_count - c0 !== 9 || onehot_err !== oh0) begin
      n_fail++;
      $display("FAIL auto_total: got changes=%0d onehot_errs=%0d, expected 9 and 0",
               chg_count - c0, onehot_err - oh0);
    end
    n_tests++;
    if (exp_q.size() != 0 || frame_cnt - f0 !== 9) begin
      n_fail++;
      $display("FAIL auto_frames: got frames=%0d left=%0d, expected 9 and 0",
               frame_cnt - f0, exp_q.size());
    end
  endtask

  task automatic test_button();
    bit ok;
    do_reset();
    wait_rel(500);
    button = 1'b0;
    wait_rel(3000);
    n_tests++;
    if (chg_count - c0 !== 0) begin
      n_fail++;
      $display("FAIL button_hold: got %0d changes, expected 0", chg_count - c0);
    end
    button = 1'b1;
    exp_q.push_back(8'h47);
    wait_chg(1, 1000, ok);
    n_tests++;
    if (!ok || chg_cyc !== 3524 || leds !== 3'b010) begin
      n_fail++;
      $display("FAIL button_resume: got ok=%0d cycle=%0d leds=%b, expected cycle=3524 leds=010",
               ok, chg_cyc, leds);
    end
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge osc_clk_in);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL button_tx: got %0d frames outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_rx_cmd();
    bit ok;
    int t0, first;
    do_reset();
    wait_rel(200);
    exp_q.push_back(8'h42);
    send_byte(8'h62, 1'b1, t0);
    wait_chg(1, 50, ok);
    first = chg_cyc;
    // Stop bit middle on the pin is t0+152; allow the input sync latency.
    n_tests++;
    if (!ok || leds !== 3'b001 || first - t0 < 152 || first - t0 > 158) begin
      n_fail++;
      $display("FAIL rx_blue: got ok=%0d leds=%b delay=%0d, expected leds=001 delay 152..158",
               ok, leds, first - t0);
    end
    exp_q.push_back(8'h52);
    wait_chg(2, LP + 100, ok);
    n_tests++;
    if (!ok || chg_cyc !== first + LP || leds !== 3'b100) begin
      n_fail++;
      $display("FAIL rx_next_step: got ok=%0d cycle=%0d leds=%b, expected cycle=%0d leds=100",
               ok, chg_cyc, leds, first + LP);
    end
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge osc_clk_in);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rx_tx_reports: got %0d frames outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_bad_rx();
    bit ok;
    int t0;
    do_reset();
    button = 1'b0;
    repeat (10) @(negedge osc_clk_in);
    send_byte(8'h41, 1'b1, t0);
    send_byte(8'h67, 1'b0, t0);
    uart_rxd = 1'b0;
    repeat (3) @(negedge osc_clk_in);
    uart_rxd = 1'b1;
    repeat (200) @(negedge osc_clk_in);
    n_tests++;
    if (chg_count - c0 !== 0 || leds !== 3'b100) begin
      n_fail++;
      $display("FAIL bad_rx_state: got changes=%0d leds=%b, expected 0 and 100",
               chg_count - c0, leds);
    end
    n_tests++;
    if (frame_cnt - f0 !== 0) begin
      n_fail++;
      $display("FAIL bad_rx_tx: got %0d frames, expected 0", frame_cnt - f0);
    end
    exp_q.push_back(8'h47);
    send_byte(8'h67, 1'b1, t0);
    wait_chg(1, 50, ok);
    n_tests++;
    if (!ok || leds !== 3'b010) begin
      n_fail++;
      $display("FAIL held_cmd: got ok=%0d leds=%b, expected leds=010", ok, leds);
    end
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge osc_clk_in);
    n_tests++;
    if (exp_q.size() != 0 || frame_cnt - f0 !== 1) begin
      n_fail++;
      $display("FAIL held_cmd_tx: got frames=%0d left=%0d, expected 1 and 0",
               frame_cnt - f0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_tx();
    int t0;
    bit low_seen;
    do_reset();
    wait_rel(20);
    exp_q.push_back(8'h42);
    send_byte(8'h62, 1'b1, t0);
    repeat (20) @(negedge osc_clk_in);
    osc_reset_ = 1'b0;
    #1;
    n_tests++;
    if (uart_txd !== 1'b1 || leds !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_mid_tx: got txd=%b leds=%b, expected 1 and 100", uart_txd, leds);
    end
    do_reset();
    low_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge osc_clk_in);
      if (uart_txd !== 1'b1) low_seen = 1'b1;
    end
    n_tests++;
    if (low_seen || frame_cnt - f0 !== 0) begin
      n_fail++;
      $display("FAIL reset_leftover: got low_seen=%0d frames=%0d, expected 0 and 0",
               low_seen, frame_cnt - f0);
    end
  endtask

  initial begin
    test_reset();
    test_autostep();
    test_button();
    test_rx_cmd();
    test_bad_rx();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/example_top.md
Name: example_top

Overview:
- Top-level demo block: cycles an RGB LED through red, green and blue at a fixed period.
- Reports each colour change as an ASCII character on a UART transmitter (8N1).
- Accepts single-character colour commands on a UART receiver.
- Sits directly on board pins: oscillator clock, push button, RGB LED, UART.

Parameters:
- LED_PERIOD, 1024, clock cycles per colour step (>=2).
- BAUD_DIV, 16, clock cycles per UART bit (>=4, even).

Ports:
- osc_clk_in  input  1  oscillator clock; all logic on its rising edge.
- osc_reset_  input  1  asynchronous active-low reset.
- led_red  output  1  red LED, active-high.
- led_green  output  1  green LED, active-high.
- led_blue  output  1  blue LED, active-high.
- button  input  1  push button, active-low (1 = released); asynchronous, 2-flop synchronised.
- uart_txd  output  1  UART transmit, idle high.
- uart_rxd  input  1  UART receive, idle high; asynchronous, 2-flop synchronised (sync flops reset to 1).

Behaviour:
- Reset (osc_reset_=0, async):
  - led_red=1, led_green=0, led_blue=0 (colour state RED).
  - Period counter=0; uart_txd=1; TX idle; pending-char register empty; RX idle.
- Colour FSM: states RED -> GREEN -> BLUE -> RED.
  - Exactly one LED is high at any time; LEDs are registered.
  - Period counter increments each cycle while the synchronised button is 1.
  - When the counter reaches LED_PERIOD-1: it returns to 0 and the state advances on the same edge.
  - After reset release with button released, the first change occurs LED_PERIOD cycles later.
  - Button=0 (synced): counter and state hold; the LEDs stay lit.
- Every state change (auto-step or command) requests a TX character: 'R'=0x52, 'G'=0x47, 'B'=0x42 for the new state.
  - The request goes to a one-entry pending register.
  - A newer request overwrites an unsent pending one.
- UART TX, 8N1, LSB first:
  - Start bit 0, 8 data bits, stop bit 1, each BAUD_DIV cycles.
  - When idle with a pending char: load it, clear pending, begin the start bit on the next cycle.
  - A request arriving during a frame waits as pending; the frame in progress is never aborted.
- UART RX, 8N1:
  - A falling edge on synced rxd starts a frame; re-check at BAUD_DIV/2. If it is high again, the start is false: return to idle.
  - Sample data bits at mid-bit; check stop at mid-bit. Stop=0 means a framing error: discard the byte.
  - Valid byte 'r'(0x72) -> RED, 'g'(0x67) -> GREEN, 'b'(0x62) -> BLUE.
    - The period counter is cleared and the TX report issued, even if the colour is unchanged.
    - Commands apply even while the button is held.
  - All other bytes are ignored.
- Simultaneous events:
  - An RX command and an auto-step on the same cycle: the command wins; the counter is cleared.
  - A pending write on the same cycle as a TX load: the new value is kept as pending.
- Reset mid-frame: TX line forced high immediately; partial RX byte discarded.

Decomposition:
- Package example_top_pkg:
  - Colour state enum (RED, GREEN, BLUE).
  - ASCII report constants 0x52/0x47/0x42.
  - Command constants 0x72/0x67/0x62.
- Sub-module uart_8n1: TX and RX engines, parameter BAUD_DIV.
  - Ports: clock, reset, tx_data/tx_valid/tx_ready, rx_data/rx_valid, txd, rxd.
- Colour FSM, period counter, pending register and button sync stay in the top.

Test Plan:
- Reset, button=1, rxd=1, run 10000 cycles -> LEDs change at cycles 1024 (green), 2048 (blue), 3072 (red), ...: 9 changes, exactly one LED high throughout.
- After the first change -> uart_txd frame decodes 0x47 'G', 10 bits of 16 cycles; line high between frames.
- button=0 from cycle 500 to 3000 -> no LED change until cycle 3524 (counter held at 500, then 524 more cycles to reach 1024).
- Send 0x62 on rxd at BAUD_DIV=16 -> within 1 cycle of the stop mid-sample, led_blue=1; TX emits 0x42; next auto-step 1024 cycles later to red.
- Send 0x41 'A', and a frame with stop bit 0 -> no state change, no TX frame.
- Assert osc_reset_ mid TX frame -> uart_txd=1 immediately, LEDs red; after release, no leftover frame.
